// File: rtl/set_ctrl_multipass.sv
// Multi-pass SET controller: START/BUSY passes, then DONE with optional valid/ack hold.
// Sequences the accumulator datapath and coordinate generator for each evaluation pass.
module set_ctrl_multipass #(
  parameter int CNT_W      = 4,
  parameter int PASS_W     = 2,
  parameter bit HOLD_VALID = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  busy_len_i,
  input  logic [PASS_W-1:0] pass_num_i,
  input  logic              abort_i,
  input  logic              ack_i,
  output logic              valid_o,
  output logic              busy_o,
  output logic              acc_en_o,
  output logic              acc_clear_o,
  output logic              coord_en_o,
  output logic              buffer_en_o,
  output logic              clear_o,
  output logic [PASS_W-1:0] pass_idx_o,
  output logic [CNT_W-1:0]  cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);
  localparam logic [PASS_W-1:0] ONE_P = PASS_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [PASS_W-1:0]   pidx_q, pidx_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic                done_exit;

  assign done_exit = (!HOLD_VALID) || ack_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    pidx_d   = pidx_q;
    passes_d = passes_q;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d  = S_START;
          len_d    = busy_len_i;
          passes_d = (pass_num_i == '0) ? ONE_P : pass_num_i;
          pidx_d   = '0;
          cnt_d    = '0;
        end
      end
      S_START: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        // Abort wins over terminal count; counter stops at len so it never wraps.
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == len_q) begin
          if (pidx_q == passes_q - ONE_P) begin
            state_d = S_DONE;
          end else begin
            state_d = S_START;
            pidx_d  = pidx_q + ONE_P;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_DONE: begin
        if (done_exit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      pidx_q   <= '0;
      passes_q <= ONE_P;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      pidx_q   <= pidx_d;
      passes_q <= passes_d;
    end
  end

  assign valid_o     = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign acc_en_o    = (state_q == S_BUSY);
  assign acc_clear_o = (state_q == S_START);
  assign coord_en_o  = (state_q == S_START);
  assign buffer_en_o = (state_q == S_IDLE) && en_i;
  assign clear_o     = (state_q == S_DONE) && done_exit;
  assign pass_idx_o  = pidx_q;
  assign cnt_o       = cnt_q;

endmodule
